// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_pkg                                                             |
// | Shared types and geometry helpers for the convolution tile control.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Latched tile geometry, already reduced to loop bounds
  typedef struct packed {
    logic [2:0] k;
    logic [2:0] s;
    logic [7:0] tc;
    logic [7:0] ro;
    logic [7:0] co;
    logic [7:0] sl;
    logic [7:0] bl;
  } cfg_t;

  function automatic logic [7:0] out_dim(input logic [7:0] t, input logic [2:0] k,
                                         input logic [2:0] s);
    logic [7:0] d;
    d = '0;
    if (s != 3'd0 && {5'd0, k} <= t)
      d = (t - {5'd0, k}) / {5'd0, s} + 8'd1;
    return d;
  endfunction

  function automatic longint op_count(input int k, input int ro, input int co,
                                      input int sl, input int bl);
    return longint'(k) * k * ro * co * sl * bl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_token_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_token_delay                                                       |
// | Fixed-depth shift register carrying {valid, flag, addr} tokens.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_token_delay #(
  parameter int AW    = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic          out_first,
  output logic [AW-1:0] out_addr
);

  localparam int c_tok_w = AW + 2;

  generate
    if (DEPTH == 0) begin : g_pass
      assign {out_valid, out_first, out_addr} = {in_valid, in_first, in_addr};
    end else begin : g_shift
      logic [c_tok_w-1:0] r_sr [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int n = 0; n < DEPTH; n++) r_sr[n] <= '0;
        end else begin
          r_sr[0] <= {in_valid, in_first, in_addr};
          for (int n = 1; n < DEPTH; n++) r_sr[n] <= r_sr[n-1];
        end
      end

      assign {out_valid, out_first, out_addr} = r_sr[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/conv_tile_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_tile_ctrl                                                       |
// | Runtime-configured loop sequencer and buffer addressing for one tile.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv_tile_ctrl
  import conv_pkg::*;
#(
  parameter int AW         = 16,
  parameter int KMAX       = 7,
  parameter int DMAX       = 64,
  parameter int X          = 4,
  parameter int Y          = 4,
  parameter int PIPE_DELAY = 37,
  parameter int WB_DELAY   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    cfg_k,
  input  logic [2:0]    cfg_s,
  input  logic [7:0]    cfg_tr,
  input  logic [7:0]    cfg_tc,
  input  logic [7:0]    cfg_tm,
  input  logic [7:0]    cfg_tn,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          op_valid,
  output logic          kernel_start,
  output logic [AW-1:0] in_fm_rd_addr,
  output logic [AW-1:0] weight_rd_addr,
  output logic          out_fm_rd_ena,
  output logic          acc_first,
  output logic [AW-1:0] out_fm_rd_addr,
  output logic          out_fm_wr_ena,
  output logic [AW-1:0] out_fm_wr_addr
);

  localparam int     c_pend_w   = $clog2(PIPE_DELAY + 2) + 1;
  localparam longint c_addr_lim = longint'(1) << AW;

  state_t r_state, w_state_nx;
  cfg_t   r_cfg, w_cfg;
  logic   w_cfg_ok;

  logic [2:0] r_j, r_i;
  logic [7:0] r_col, r_row, r_slc, r_blk;
  logic w_j_last, w_i_last, w_col_last, w_row_last, w_slc_last, w_blk_last;
  logic w_issue, w_win_last, w_tile_last, w_last_tok, w_drain_done;
  logic [AW-1:0] w_in_addr, w_w_addr, w_out_addr;

  logic r_op_valid, r_kernel_start, r_cfg_err, r_done;
  logic [AW-1:0] r_in_addr, r_w_addr;
  logic r_tok_valid, r_tok_first;
  logic [AW-1:0] r_tok_addr;
  logic [c_pend_w-1:0] r_rd_pend;

  logic w_rd_valid, w_rd_first, w_wr_valid, w_wr_last;
  logic [AW-1:0] w_rd_addr, w_wr_addr;

  always_comb begin
    w_cfg.k  = cfg_k;
    w_cfg.s  = cfg_s;
    w_cfg.tc = cfg_tc;
    w_cfg.ro = out_dim(cfg_tr, cfg_k, cfg_s);
    w_cfg.co = out_dim(cfg_tc, cfg_k, cfg_s);
    w_cfg.sl = 8'(int'(cfg_tm) / X);
    w_cfg.bl = 8'(int'(cfg_tn) / Y);
    w_cfg_ok = 1'b1;
    if (cfg_k == 3'd0 || int'(cfg_k) > KMAX) w_cfg_ok = 1'b0;
    if (cfg_s == 3'd0 || cfg_s > cfg_k) w_cfg_ok = 1'b0;
    if (cfg_tr < {5'd0, cfg_k} || int'(cfg_tr) > DMAX) w_cfg_ok = 1'b0;
    if (cfg_tc < {5'd0, cfg_k} || int'(cfg_tc) > DMAX) w_cfg_ok = 1'b0;
    if (cfg_tm == 8'd0 || int'(cfg_tm) % X != 0 || int'(cfg_tm) > DMAX) w_cfg_ok = 1'b0;
    if (cfg_tn == 8'd0 || int'(cfg_tn) % Y != 0 || int'(cfg_tn) > DMAX) w_cfg_ok = 1'b0;
    // Highest address + 1 of every buffer must fit in AW bits
    if (longint'(cfg_tr) * longint'(cfg_tc) > c_addr_lim) w_cfg_ok = 1'b0;
    if (longint'(w_cfg.sl) * longint'(w_cfg.bl) * longint'(cfg_k) * longint'(cfg_k)
        > c_addr_lim) w_cfg_ok = 1'b0;
    if (longint'(w_cfg.bl) * longint'(w_cfg.ro) * longint'(w_cfg.co) > c_addr_lim)
      w_cfg_ok = 1'b0;
  end

  assign w_j_last    = (r_j == r_cfg.k - 3'd1);
  assign w_i_last    = (r_i == r_cfg.k - 3'd1);
  assign w_col_last  = (r_col == r_cfg.co - 8'd1);
  assign w_row_last  = (r_row == r_cfg.ro - 8'd1);
  assign w_slc_last  = (r_slc == r_cfg.sl - 8'd1);
  assign w_blk_last  = (r_blk == r_cfg.bl - 8'd1);
  assign w_win_last  = w_j_last && w_i_last;
  assign w_tile_last = w_win_last && w_col_last && w_row_last && w_slc_last && w_blk_last;

  assign w_in_addr  = AW'((int'(r_row) * int'(r_cfg.s) + int'(r_i)) * int'(r_cfg.tc)
                          + int'(r_col) * int'(r_cfg.s) + int'(r_j));
  assign w_w_addr   = AW'((int'(r_blk) * int'(r_cfg.sl) + int'(r_slc)) * int'(r_cfg.k) * int'(r_cfg.k)
                          + int'(r_i) * int'(r_cfg.k) + int'(r_j));
  assign w_out_addr = AW'(int'(r_blk) * int'(r_cfg.ro) * int'(r_cfg.co)
                          + int'(r_row) * int'(r_cfg.co) + int'(r_col));

  // The tile's final token is the only one leaving the read stage while in
  // DRAIN with nothing behind it; its tag rides the write stage to end the tile.
  assign w_last_tok   = (r_state == ST_DRAIN) && w_rd_valid && !r_tok_valid &&
                        (r_rd_pend == c_pend_w'(1));
  assign w_drain_done = (r_state == ST_DRAIN) && w_wr_valid && w_wr_last;

  always_comb begin
    w_state_nx = r_state;
    w_issue    = 1'b0;
    case (r_state)
      ST_IDLE:  if (start && w_cfg_ok) w_state_nx = ST_RUN;
      ST_RUN: begin
        w_issue = !stall;
        if (w_issue && w_tile_last) w_state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (w_drain_done) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cfg   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == ST_IDLE && start && w_cfg_ok) r_cfg <= w_cfg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_j <= '0; r_i <= '0; r_col <= '0; r_row <= '0; r_slc <= '0; r_blk <= '0;
    end else if (r_state == ST_IDLE) begin
      r_j <= '0; r_i <= '0; r_col <= '0; r_row <= '0; r_slc <= '0; r_blk <= '0;
    end else if (w_issue) begin
      r_j <= w_j_last ? 3'd0 : r_j + 3'd1;
      if (w_j_last) begin
        r_i <= w_i_last ? 3'd0 : r_i + 3'd1;
        if (w_i_last) begin
          r_col <= w_col_last ? 8'd0 : r_col + 8'd1;
          if (w_col_last) begin
            r_row <= w_row_last ? 8'd0 : r_row + 8'd1;
            if (w_row_last) begin
              r_slc <= w_slc_last ? 8'd0 : r_slc + 8'd1;
              if (w_slc_last) r_blk <= w_blk_last ? 8'd0 : r_blk + 8'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_valid     <= 1'b0;
      r_kernel_start <= 1'b0;
      r_in_addr      <= '0;
      r_w_addr       <= '0;
      r_tok_valid    <= 1'b0;
      r_tok_first    <= 1'b0;
      r_tok_addr     <= '0;
      r_cfg_err      <= 1'b0;
      r_done         <= 1'b0;
      r_rd_pend      <= '0;
    end else begin
      r_op_valid     <= w_issue;
      r_kernel_start <= w_issue && (r_i == 3'd0) && (r_j == 3'd0);
      r_in_addr      <= w_issue ? w_in_addr : '0;
      r_w_addr       <= w_issue ? w_w_addr : '0;
      r_tok_valid    <= w_issue && w_win_last;
      r_tok_first    <= w_issue && w_win_last && (r_slc == 8'd0);
      r_tok_addr     <= (w_issue && w_win_last) ? w_out_addr : '0;
      r_cfg_err      <= (r_state == ST_IDLE) && start && !w_cfg_ok;
      r_done         <= w_drain_done;
      r_rd_pend      <= r_rd_pend + c_pend_w'(r_tok_valid) - c_pend_w'(w_rd_valid);
    end
  end

  wb_token_delay #(.AW(AW), .DEPTH(PIPE_DELAY)) u_rd_dly (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_tok_valid),
    .in_first  (r_tok_first),
    .in_addr   (r_tok_addr),
    .out_valid (w_rd_valid),
    .out_first (w_rd_first),
    .out_addr  (w_rd_addr)
  );

  // Flag bit of the write stage carries the end-of-tile tag instead of slice-0
  wb_token_delay #(.AW(AW), .DEPTH(WB_DELAY)) u_wr_dly (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_rd_valid),
    .in_first  (w_last_tok),
    .in_addr   (w_rd_addr),
    .out_valid (w_wr_valid),
    .out_first (w_wr_last),
    .out_addr  (w_wr_addr)
  );

  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign cfg_err        = r_cfg_err;
  assign op_valid       = r_op_valid;
  assign kernel_start   = r_kernel_start;
  assign in_fm_rd_addr  = r_in_addr;
  assign weight_rd_addr = r_w_addr;
  assign out_fm_rd_ena  = w_rd_valid && !w_rd_first;
  assign acc_first      = w_rd_valid && w_rd_first;
  assign out_fm_rd_addr = w_rd_addr;
  assign out_fm_wr_ena  = w_wr_valid;
  assign out_fm_wr_addr = w_wr_addr;

endmodule
`default_nettype wire
